imm_gen_pipe: RTL and testbench

// Registered immediate generator for the decode stage. Accepts an instruction word plus immediate-format select,

---
 rtl/imm_pkg.sv | 43 ++++
 rtl/skid_buf.sv | 68 ++++++
 rtl/imm_gen_pipe.sv | 59 +++++
 tb/tb_imm_gen_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and the pure-combinational immediate decoder used by imm_gen_pipe.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_SHAMT = 3'b100,
    IMM_CSR   = 3'b101,
    IMM_RSVD  = 3'b110,
    IMM_U     = 3'b111
  } imm_src_e;

  localparam logic [1:0] SKID_EMPTY = 2'd0;
  localparam logic [1:0] SKID_ONE   = 2'd1;
  localparam logic [1:0] SKID_FULL  = 2'd2;

  // Returns {illegal, imm[63:0]}; callers keep the low XLEN bits. Any src that
  // matches no legal code (reserved or X/Z) takes the illegal path with imm 0.
  function automatic logic [64:0] imm_decode(input logic [31:0] instr,
                                             input logic [2:0]  src,
                                             input logic        is64);
    logic [63:0] sx;
    logic [63:0] imm;
    logic        ill;
    sx  = {64{instr[31]}};
    imm = '0;
    ill = 1'b0;
    case (src)
      IMM_I:     imm = {sx[63:12], instr[31:20]};
      IMM_S:     imm = {sx[63:12], instr[31:25], instr[11:7]};
      IMM_B:     imm = {sx[63:12], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:     imm = {sx[63:20], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SHAMT: imm = is64 ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      IMM_CSR:   imm = {59'b0, instr[19:15]};
      IMM_U:     imm = {sx[63:32], instr[31:12], 12'b0};
      default:   ill = 1'b1;
    endcase
    return {ill, imm};
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry (output reg + skid) valid/ready buffer; strict FIFO order, sync flush.
// state      | meaning
// SKID_EMPTY | nothing held, out_valid low
// SKID_ONE   | output reg holds the head entry
// SKID_FULL  | output reg plus skid entry held, in_ready low
module skid_buf
  import imm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   state;
  logic [W-1:0] skid;
  logic         in_fire;
  logic         out_fire;

  assign in_ready  = (state != SKID_FULL);
  assign out_valid = (state != SKID_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SKID_EMPTY;
      out_data <= '0;
      skid     <= '0;
    end else if (flush) begin
      state <= SKID_EMPTY;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (in_fire) begin
            out_data <= in_data;
            state    <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (in_fire && out_fire) begin
            out_data <= in_data;
          end else if (in_fire) begin
            skid  <= in_data;
            state <= SKID_FULL;
          end else if (out_fire) begin
            state <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            out_data <= skid;
            state    <= SKID_ONE;
          end
        end
        default: state <= SKID_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: combinational decode feeding a 2-entry skid buffer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int W = 1 + TAG_W + XLEN;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  logic [64:0]  dec;
  logic [W-1:0] buf_in;
  logic [W-1:0] buf_out;

  assign dec    = imm_decode(in_instr, in_imm_src, XLEN == 64);
  assign buf_in = {dec[64], in_tag, dec[XLEN-1:0]};

  generate
    if (XLEN < 64) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^dec[63:XLEN];
    end
  endgenerate

  skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign {out_illegal, out_tag, out_imm} = buf_out;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one input stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm;
  logic [7:0]  out_tag;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [7:0] tg);
    in_valid   = 1'b1;
    in_instr   = ins;
    in_imm_src = src;
    in_tag     = tg;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic [31:0] imm, input logic ill);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_imm"}, 64'(out_imm), 64'(imm));
    chk({tag, "_ill"}, 64'(out_illegal), 64'(ill));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    in_imm_src = '0; in_tag = '0; out_ready = 1'b1;
    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_ill", 64'(out_illegal), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // format sweep, out_ready high, one result per cycle
    send(32'hFFF00093, 3'b000, 8'h11); chk_out("i_neg1", 32'hFFFFFFFF, 1'b0);
    chk("i_tag", 64'(out_tag), 64'h11);
    chk("i_neg1_64", out_imm64, 64'hFFFFFFFF_FFFFFFFF);
    send(32'hFE000EE3, 3'b010, 8'h12); chk_out("b_m4", 32'hFFFFFFFC, 1'b0);
    send(32'h00512423, 3'b001, 8'h13); chk_out("s_p8", 32'h00000008, 1'b0);
    send(32'hFE112E23, 3'b001, 8'h14); chk_out("s_m4", 32'hFFFFFFFC, 1'b0);
    send(32'h800000EF, 3'b011, 8'h15); chk_out("j_sign", 32'hFFF00000, 1'b0);
    send(32'h008000EF, 3'b011, 8'h16); chk_out("j_b3", 32'h00000008, 1'b0);
    send(32'h001000EF, 3'b011, 8'h17); chk_out("j_b11", 32'h00000800, 1'b0);
    send(32'h000FF0EF, 3'b011, 8'h18); chk_out("j_hi", 32'h000FF000, 1'b0);
    send(32'h01F01013, 3'b100, 8'h19); chk_out("sh_1f", 32'h0000001F, 1'b0);
    send(32'h000F8073, 3'b101, 8'h1A); chk_out("csr_1f", 32'h0000001F, 1'b0);
    send(32'h800A8073, 3'b101, 8'h1B); chk_out("csr_zx", 32'h00000015, 1'b0);
    send(32'h12345037, 3'b111, 8'h1C); chk_out("u_pos", 32'h12345000, 1'b0);
    send(32'hFFFFFFFF, 3'b110, 8'h1D); chk_out("rsvd", 32'h00000000, 1'b1);
    chk("rsvd_tag", 64'(out_tag), 64'h1D);
    send(32'h00100093, 3'b000, 8'h1E); chk_out("after_rsvd", 32'h00000001, 1'b0);

    // XLEN=64 checks
    send(32'h800000B7, 3'b111, 8'h20);
    chk("u64_sx", out_imm64, 64'hFFFFFFFF_80000000);
    chk("u32_sx", 64'(out_imm), 64'h80000000);
    send(32'h03F01013, 3'b100, 8'h21);
    chk("sh64_3f", out_imm64, 64'h3F);
    chk("sh32_1f", 64'(out_imm), 64'h1F);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // backpressure: tags 1,2,3 with out_ready low
    out_ready = 1'b0;
    send(32'h00100093, 3'b000, 8'd1);
    chk("bp1_tag", 64'(out_tag), 64'd1);
    chk("bp1_ready", 64'(in_ready), 64'd1);
    send(32'h00200093, 3'b000, 8'd2);
    chk("bp2_ready", 64'(in_ready), 64'd0);
    chk("bp2_tag", 64'(out_tag), 64'd1);
    send(32'h00300093, 3'b000, 8'd3);
    chk("bp3_tag", 64'(out_tag), 64'd1);
    chk("bp3_imm", 64'(out_imm), 64'd1);
    chk("bp3_ready", 64'(in_ready), 64'd0);
    tick();
    chk("bp4_tag_stable", 64'(out_tag), 64'd1);
    chk("bp4_imm_stable", 64'(out_imm), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("rel1_tag", 64'(out_tag), 64'd2);
    chk("rel1_imm", 64'(out_imm), 64'd2);
    chk("rel1_ready", 64'(in_ready), 64'd1);
    tick();
    chk("rel2_tag", 64'(out_tag), 64'd3);
    chk("rel2_imm", 64'(out_imm), 64'd3);
    chk("rel2_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("rel3_valid", 64'(out_valid), 64'd0);

    // flush while FULL with a simultaneous input
    out_ready = 1'b0;
    send(32'h00500093, 3'b000, 8'd5);
    send(32'h00600093, 3'b000, 8'd6);
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_tag = 8'd9;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_after1", 64'(out_valid), 64'd0);
    tick();
    chk("fl_after2", 64'(out_valid), 64'd0);

    // async reset mid-stall
    out_ready = 1'b0;
    send(32'h00700093, 3'b000, 8'd7);
    send(32'h00800093, 3'b000, 8'd8);
    in_valid = 1'b0;
    chk("pre_rst_tag", 64'(out_tag), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_imm", 64'(out_imm), 64'd0);
    chk("arst_tag", 64'(out_tag), 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
